spi_slave_handler: RTL

SPI_SLAVE_HANDLER -- requirements
Module: spi_slave_handler

---
 rtl/spi_slave_handler.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_handler.sv
// SPI mode-0 slave: oversampled SCLK/CS/MOSI in the clk domain, byte-wide RX strobe,
// and a small TX FIFO feeding MISO (IDLE_BYTE when it runs dry).
module spi_slave_handler #(
  parameter int unsigned TX_FIFO_DEPTH = 4,
  parameter logic [7:0]  IDLE_BYTE     = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] rx_index,
  output logic       frame_start,
  output logic       frame_end,
  output logic       tx_underrun,
  output logic       busy
);

  localparam int unsigned AW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sclk_sync_q, cs_sync_q;
  logic [1:0]      mosi_sync_q;
  logic [1:0]      flush_q, flush_d;
  logic            arm_q, arm_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_pend_q, rx_pend_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_index_q, rx_index_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            miso_q, miso_d;
  logic            oe_q, oe_d;
  logic            any_done_q, any_done_d;
  logic            fs_q, fs_d, fe_q, fe_d, ur_q, ur_d;
  logic            busy_q, busy_d;
  logic            tx_ready_q, tx_ready_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [TX_FIFO_DEPTH];

  logic            sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic            fifo_empty, push, pop, load;
  logic [7:0]      next_byte;

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall    = ~cs_sync_q[1] & cs_sync_q[2] & arm_q;
  assign cs_rise    = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s     = mosi_sync_q[1];
  assign fifo_empty = (count_q == '0);

  // Next-state, datapath and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_pend_d  = 1'b0;
    rx_valid_d = rx_pend_q;
    rx_index_d = rx_valid_q ? 8'(rx_index_q + 8'd1) : rx_index_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    any_done_d = any_done_q;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    ur_d       = 1'b0;
    load       = 1'b0;
    next_byte  = IDLE_BYTE;
    // Presets in the synchronizer are not real CS history; arm only once the pipe holds live samples.
    flush_d    = (flush_q == 2'd3) ? flush_q : 2'(flush_q + 2'd1);
    arm_d      = arm_q | ((flush_q == 2'd3) & cs_sync_q[2]);

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = 3'd0;
          rx_index_d = 8'd0;
          any_done_d = 1'b0;
          oe_d       = 1'b1;
          fs_d       = 1'b1;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          oe_d      = 1'b0;
          bit_cnt_d = 3'd0;
          fe_d      = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_pend_d  = 1'b1;
            any_done_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            miso_d     = tx_shift_q[6];
          end else if (any_done_q) begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      next_byte  = fifo_empty ? IDLE_BYTE : mem_q[rd_ptr_q];
      tx_shift_d = next_byte;
      miso_d     = next_byte[7];
      ur_d       = fifo_empty;
    end

    push       = tx_valid & tx_ready_q;
    pop        = load & ~fifo_empty;
    wr_ptr_d   = push ? AW'(wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? AW'(rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d    = CW'(count_q + CW'(push) - CW'(pop));
    tx_ready_d = (count_d != CW'(TX_FIFO_DEPTH));
    busy_d     = (state_d == ACTIVE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      flush_q     <= 2'd0;
      arm_q       <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      rx_data_q   <= 8'h00;
      rx_pend_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_index_q  <= 8'd0;
      tx_shift_q  <= 8'h00;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      any_done_q  <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ur_q        <= 1'b0;
      busy_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      flush_q     <= flush_d;
      arm_q       <= arm_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_pend_q   <= rx_pend_d;
      rx_valid_q  <= rx_valid_d;
      rx_index_q  <= rx_index_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      any_done_q  <= any_done_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ur_q        <= ur_d;
      busy_q      <= busy_d;
      tx_ready_q  <= tx_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_index    = rx_index_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign tx_underrun = ur_q;
  assign busy        = busy_q;

endmodule
